// File: rtl/sat_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sat_arith_pkg
// Description : Saturating-arithmetic helpers shared by the saturating stages.
// Revision    : 1.0 - initial release
// ============================================================================
package sat_arith_pkg;

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

    // An overflowing add can only run off the end it is heading toward, which
    // the sign of the incoming operand tells us.
    function automatic int clamp(input int w, input logic sign, input logic ovf, input int sum);
        if (!ovf)
            return sum;
        else if (sign)
            return sat_min(w);
        else
            return sat_max(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/signed_add_with_overflow.sv
`default_nettype none
// ============================================================================
// Module      : signed_add_with_overflow
// Description : Combinational W-bit two's-complement adder with overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_add_with_overflow #(
    parameter int W = 4
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                overflow
);

    assign sum      = a + b;
    assign overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);

endmodule
`default_nettype wire

// File: rtl/signed_sat_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : signed_sat_accumulator
// Description : Frame-based saturating signed accumulator over N operands.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_sat_accumulator
    import sat_arith_pkg::*;
#(
    parameter int W = 4,
    parameter int N = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arg_vld,
    input  logic signed [W-1:0]        arg,
    output logic                       res_vld,
    output logic signed [W-1:0]        res,
    output logic                       res_sat,
    output logic [$clog2(N+1)-1:0]     res_sat_cnt
);

    localparam int                c_cnt_w = $clog2(N + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(N - 1);

    logic signed [W-1:0]  r_acc;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_sat_flag;
    logic [c_cnt_w-1:0]   r_sat_cnt;
    logic                 r_res_vld;
    logic signed [W-1:0]  r_res;
    logic                 r_res_sat;
    logic [c_cnt_w-1:0]   r_res_sat_cnt;

    logic signed [W-1:0]  w_sum;
    logic                 w_ovf;
    int                   w_clamped;
    logic signed [W-1:0]  w_next;
    logic                 w_last;
    logic                 w_flag_next;
    logic [c_cnt_w-1:0]   w_sat_cnt_next;

    signed_add_with_overflow #(
        .W (W)
    ) u_add (
        .a        (r_acc),
        .b        (arg),
        .sum      (w_sum),
        .overflow (w_ovf)
    );

    assign w_clamped      = clamp(W, arg[W-1], w_ovf, int'(w_sum));
    assign w_next         = w_clamped[W-1:0];
    assign w_last         = (r_cnt == c_last);
    assign w_flag_next    = r_sat_flag | w_ovf;
    assign w_sat_cnt_next = r_sat_cnt + c_cnt_w'(w_ovf);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc         <= '0;
            r_cnt         <= '0;
            r_sat_flag    <= 1'b0;
            r_sat_cnt     <= '0;
            r_res_vld     <= 1'b0;
            r_res         <= '0;
            r_res_sat     <= 1'b0;
            r_res_sat_cnt <= '0;
        end else begin
            r_res_vld <= 1'b0;
            if (arg_vld) begin
                if (w_last) begin
                    // Publish the frame and restart from zero on the same edge.
                    r_res         <= w_next;
                    r_res_sat     <= w_flag_next;
                    r_res_sat_cnt <= w_sat_cnt_next;
                    r_res_vld     <= 1'b1;
                    r_acc         <= '0;
                    r_cnt         <= '0;
                    r_sat_flag    <= 1'b0;
                    r_sat_cnt     <= '0;
                end else begin
                    r_acc      <= w_next;
                    r_cnt      <= r_cnt + 1'b1;
                    r_sat_flag <= w_flag_next;
                    r_sat_cnt  <= w_sat_cnt_next;
                end
            end
        end
    end

    assign res_vld     = r_res_vld;
    assign res         = r_res;
    assign res_sat     = r_res_sat;
    assign res_sat_cnt = r_res_sat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_signed_sat_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_signed_sat_accumulator
// Description : Scoreboard bench for signed_sat_accumulator with W=4, N=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_sat_accumulator;

    localparam int W    = 4;
    localparam int N    = 4;
    localparam int CW   = $clog2(N + 1);
    localparam int VMAX = 7;
    localparam int VMIN = -8;

    typedef struct {
        int res;
        int sat;
        int scnt;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                arg_vld;
    logic signed [W-1:0] arg;
    logic                res_vld;
    logic signed [W-1:0] res;
    logic                res_sat;
    logic [CW-1:0]       res_sat_cnt;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pulses = 0;
    int   n_pushed = 0;
    int   m_acc, m_cnt, m_flag, m_scnt;

    signed_sat_accumulator #(
        .W (W),
        .N (N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arg_vld     (arg_vld),
        .arg         (arg),
        .res_vld     (res_vld),
        .res         (res),
        .res_sat     (res_sat),
        .res_sat_cnt (res_sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_acc = 0; m_cnt = 0; m_flag = 0; m_scnt = 0;
    endtask

    // Reference works on plain integers: exact sum, then clamp by range.
    task automatic send(input int a);
        int   t;
        exp_t e;
        arg_vld = 1'b1;
        arg     = W'(a);
        t = m_acc + a;
        if (t > VMAX) begin t = VMAX; m_flag = 1; m_scnt++; end
        else if (t < VMIN) begin t = VMIN; m_flag = 1; m_scnt++; end
        m_acc = t;
        m_cnt++;
        if (m_cnt == N) begin
            e.res = m_acc; e.sat = m_flag; e.scnt = m_scnt;
            q.push_back(e);
            n_pushed++;
            model_clear();
        end
        @(negedge clk);
        arg_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        arg_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_vld"},  int'(res_vld), 0);
        check({tag, "_res"},  int'(res), 0);
        check({tag, "_sat"},  int'(res_sat), 0);
        check({tag, "_scnt"}, int'(res_sat_cnt), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (res_vld) begin
            n_pulses++;
            if (q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                e = q.pop_front();
                check("res",      int'(res), e.res);
                check("res_sat",  int'(res_sat), e.sat);
                check("res_scnt", int'(res_sat_cnt), e.scnt);
            end
        end
    end

    initial begin
        int budget;
        rst = 1'b1; arg_vld = 1'b0; arg = '0;
        model_clear();
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;

        // Plain frame, positive and negative saturation
        send(1); send(2); send(3); send(1);
        send(4); send(7); send(1); send(-2);
        send(-4); send(-7); send(-1); send(0);
        idle(2);
        check("hold_res", int'(res), -8);
        check("hold_vld", int'(res_vld), 0);

        // Gaps, then back-to-back frames
        send(1); idle(3); send(1); send(1); send(1);
        send(2); send(2); send(2); send(2);
        idle(2);

        // Mid-frame reset; the operand presented with reset must be dropped
        send(3); send(3);
        rst = 1'b1; arg_vld = 1'b1; arg = 4'sd5;
        model_clear();
        @(negedge clk);
        check_zero_outputs("in_rst");
        rst = 1'b0; arg_vld = 1'b0;
        @(negedge clk);
        check_zero_outputs("post_rst");
        send(1); send(1); send(1); send(1);
        idle(2);

        // Random operands with random gaps
        for (int i = 0; i < 60; i++) begin
            send(int'($urandom_range(0, 15)) - 8);
            idle(int'($urandom_range(0, 2)));
        end

        budget = 20;
        while (q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("drain", q.size(), 0);
        check("pulse_count", n_pulses, n_pushed);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
